// File: rtl/btb_ctrl.sv
// Branch target buffer controller for a 256x32 dual-port SRAM.
// Port 0 handles fetch lookups. Port 1 handles updates and the clear sweep. In-flight writes are forwarded to lookups.
module btb_ctrl #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 7,
  parameter int TGT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             lookup_valid,
  output logic             lookup_ready,
  input  logic [31:0]      lookup_pc,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [31:0]      resp_target,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [31:0]      upd_pc,
  input  logic [31:0]      upd_target,
  input  logic             upd_inval,
  output logic             init_done,
  output logic             sram_csb0,
  output logic             sram_web0,
  output logic [IDX_W-1:0] sram_addr0,
  input  logic [31:0]      sram_dout0,
  output logic             sram_csb1,
  output logic             sram_web1,
  output logic [IDX_W-1:0] sram_addr1,
  output logic [31:0]      sram_din1
);

  localparam int HI_LSB = TGT_W + 2;
  localparam int TAG_LSB = IDX_W + 2;
  localparam int VBIT = TAG_W + TGT_W;

  // Handshake: a lookup or update is taken in any cycle where valid && ready.
  // Ready is high for the whole of RUN and low for the whole of INIT.
  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic               run;

  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic [IDX_W-1:0]   up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_rep;
  logic [31:0]        up_word;

  logic               pw_valid;
  logic [IDX_W-1:0]   pw_idx;
  logic [31:0]        pw_data;

  logic               fsel_v;
  logic [31:0]        fsel_d;
  logic               fwd_v;
  logic [31:0]        fwd_d;
  logic [TAG_W-1:0]   r_tag;
  logic [31-HI_LSB:0] r_hi;
  logic [31:0]        entry;
  logic               unused;

  assign run    = (state == RUN);
  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+TAG_W+1:TAG_LSB];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:TAG_LSB];
  assign up_rep = (upd_target[31:HI_LSB] == upd_pc[31:HI_LSB]);
  // Invalidates and unrepresentable targets both store an all-zero (invalid) word.
  assign up_word = (upd_inval || !up_rep) ? '0 : {1'b1, up_tag, upd_target[TGT_W+1:2]};

  assign lookup_ready = run;
  assign upd_ready    = run;
  assign sram_csb0    = ~(run & lookup_valid);
  assign sram_web0    = 1'b1;
  assign sram_addr0   = run ? lk_idx : '0;

  always_comb begin
    sram_csb1  = 1'b1;
    sram_web1  = 1'b1;
    sram_addr1 = '0;
    sram_din1  = '0;
    if (!run && rst_n) begin
      sram_csb1  = 1'b0;
      sram_web1  = 1'b0;
      sram_addr1 = cnt;
    end else if (run && upd_valid) begin
      sram_csb1  = 1'b0;
      sram_web1  = 1'b0;
      sram_addr1 = up_idx;
      sram_din1  = up_word;
    end
  end

  // The write issued this cycle is newer than the one from last cycle, so it wins.
  always_comb begin
    fsel_v = 1'b0;
    fsel_d = '0;
    if (!sram_csb1 && (sram_addr1 == lk_idx)) begin
      fsel_v = 1'b1;
      fsel_d = sram_din1;
    end else if (pw_valid && (pw_idx == lk_idx)) begin
      fsel_v = 1'b1;
      fsel_d = pw_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      cnt        <= '0;
      init_done  <= 1'b0;
      resp_valid <= 1'b0;
      r_tag      <= '0;
      r_hi       <= '0;
      fwd_v      <= 1'b0;
      fwd_d      <= '0;
      pw_valid   <= 1'b0;
      pw_idx     <= '0;
      pw_data    <= '0;
    end else begin
      pw_valid   <= ~sram_csb1;
      pw_idx     <= sram_addr1;
      pw_data    <= sram_din1;
      resp_valid <= run & lookup_valid & ~flush;
      if (run && lookup_valid) begin
        r_tag <= lk_tag;
        r_hi  <= lookup_pc[31:HI_LSB];
        fwd_v <= fsel_v;
        fwd_d <= fsel_d;
      end
      case (state)
        INIT: begin
          if (flush) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              state     <= RUN;
              init_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign entry       = fwd_v ? fwd_d : sram_dout0;
  assign resp_hit    = resp_valid & entry[VBIT] & (entry[VBIT-1:TGT_W] == r_tag);
  assign resp_target = resp_hit ? {r_hi, entry[TGT_W-1:0], 2'b00} : '0;

  assign unused = ^{lookup_pc, upd_pc, upd_target};

endmodule

// File: tb/tb_btb_ctrl.sv
// Testbench for btb_ctrl. It uses a behavioural SRAM and an entry-level model of the BTB contents.
module tb_btb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        lookup_valid = 1'b0;
  logic        lookup_ready;
  logic [31:0] lookup_pc = '0;
  logic        resp_valid;
  logic        resp_hit;
  logic [31:0] resp_target;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_inval = 1'b0;
  logic        init_done;
  logic        sram_csb0, sram_web0, sram_csb1, sram_web1;
  logic [7:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_dout0 = '0;
  logic [31:0] sram_din1;

  always #5 clk = ~clk;

  btb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_pc(lookup_pc),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_target(resp_target),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_inval(upd_inval), .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_dout0(sram_dout0), .sram_csb1(sram_csb1), .sram_web1(sram_web1),
    .sram_addr1(sram_addr1), .sram_din1(sram_din1)
  );

  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (!sram_csb1 && !sram_web1) sram[sram_addr1] <= sram_din1;
    if (!sram_csb0) sram_dout0 <= sram[sram_addr0];
  end

  int total = 0;
  int bad = 0;

  bit          m_valid [256];
  int unsigned m_tag [256];
  logic [31:0] m_tgt [256];
  bit          m_run;
  int          m_cnt;
  bit          e_valid, e_hit;
  logic [31:0] e_tgt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_write(input logic [31:0] pc, input logic [31:0] tgt, input bit inv);
    int unsigned idx;
    idx = (pc >> 2) % 256;
    if (inv || ((tgt >> 26) != (pc >> 26))) begin
      m_valid[idx] = 1'b0;
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = (pc >> 10) % 128;
      m_tgt[idx]   = tgt;
    end
  endtask

  task automatic predict(input logic [31:0] pc);
    int unsigned idx;
    idx = (pc >> 2) % 256;
    e_hit = m_valid[idx] && (m_tag[idx] == (pc >> 10) % 128);
    e_tgt = e_hit ? ((pc & 32'hFC00_0000) | (m_tgt[idx] & 32'h03FF_FFFC)) : 32'h0;
  endtask

  // One clock cycle: drive the inputs, check the comb outputs, advance the model, then check after the edge.
  task automatic cyc(input bit lv, input logic [31:0] lpc, input bit uv,
                     input logic [31:0] upc, input logic [31:0] utgt,
                     input bit uinv, input bit fl);
    lookup_valid = lv; lookup_pc = lpc; upd_valid = uv;
    upd_pc = upc; upd_target = utgt; upd_inval = uinv; flush = fl;
    #1;
    check("lookup_ready", lookup_ready, m_run);
    check("upd_ready", upd_ready, m_run);
    if (!m_run) begin
      check("sweep_csb1", sram_csb1, 0);
      check("sweep_addr1", sram_addr1, m_cnt);
      check("sweep_din1", sram_din1, 0);
    end
    e_valid = 1'b0;
    if (m_run) begin
      if (uv) model_write(upc, utgt, uinv);
      if (lv && !fl) begin
        e_valid = 1'b1;
        predict(lpc);
      end
      if (fl) begin
        m_run = 1'b0;
        m_cnt = 0;
        model_clear();
      end
    end else if (fl) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == 256) m_run = 1'b1;
    end
    @(posedge clk);
    #1;
    check("resp_valid", resp_valid, e_valid);
    if (e_valid) begin
      check("resp_hit", resp_hit, e_hit);
      check("resp_target", resp_target, e_tgt);
    end
    check("init_done", init_done, m_run);
  endtask

  task automatic do_reset();
    lookup_valid = 1'b1; upd_valid = 1'b1; upd_pc = $urandom; upd_target = $urandom;
    #2 rst_n = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_lookup_ready", lookup_ready, 0);
    check("rst_upd_ready", upd_ready, 0);
    check("rst_csb0", sram_csb0, 1);
    check("rst_csb1", sram_csb1, 1);
    check("rst_web1", sram_web1, 1);
    check("rst_addr1", sram_addr1, 0);
    check("rst_din1", sram_din1, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_run = 1'b0;
    m_cnt = 0;
    model_clear();
  endtask

  task automatic sweep_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, $urandom, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] mk_pc(input int unsigned hi, input int unsigned tag, input int unsigned idx);
    return (hi << 26) | (($urandom % 512) << 17) | (tag << 10) | (idx << 2) | ($urandom % 4);
  endfunction

  initial begin
    logic [31:0] pa, pb;
    for (int i = 0; i < 256; i++) sram[i] = $urandom | 32'h8000_0000;

    // Reset, then the full clear sweep with requests held high
    do_reset();
    sweep_cycles(256);
    for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Basic update followed by a hit and by a tag miss on the same index
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_1040, 32'h0000_2000, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 32'h0000_1040, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0001_1040, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Forwarding from the same cycle and the previous cycle, then invalidate
    cyc(1'b1, 32'h0000_0C40, 1'b1, 32'h0000_0C40, 32'h0000_3000, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0C40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_0C40, 32'h0000_3000, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_0C40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Back-to-back updates to index 5: the newest one wins
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_0014, 32'h0000_4444, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0014, 1'b1, 32'h0000_0014, 32'h0000_8888, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0014, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 32'h0000_0014, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // A target that cannot be represented removes the existing entry
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_0100, 32'h8000_0000, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with a lookup in flight, then the re-sweep, then everything misses
    pa = 32'h0400_2088;
    cyc(1'b0, 32'h0, 1'b1, pa, 32'h0412_3454, 1'b0, 1'b0);
    idle(2);
    cyc(1'b1, pa, 1'b1, 32'h0000_1040, 32'h0000_2000, 1'b0, 1'b0);
    cyc(1'b1, pa, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    sweep_cycles(256);
    cyc(1'b1, pa, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_1040, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset partway through a sweep restarts it from index 0
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    sweep_cycles(100);
    do_reset();
    sweep_cycles(256);

    // Random traffic over a small set of indices and tags, so that hits and forwarding occur
    for (int n = 0; n < 1500; n++) begin
      pa = mk_pc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7));
      pb = mk_pc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7));
      cyc($urandom_range(0, 3) != 0, pa, $urandom_range(0, 1) == 1, pb,
          ($urandom_range(0, 7) == 0) ? $urandom : ((pb & 32'hFC00_0000) | ($urandom % 32'h0400_0000)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 399) == 0);
    end
    idle(260);
    for (int i = 0; i < 16; i++) cyc(1'b1, mk_pc(0, $urandom_range(0, 3), i % 8), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
